// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised progressive raster timing generator with pixel clock enable
module video_timing_gen #(
  parameter int       H_ACT  = 640,
  parameter int       H_FP   = 16,
  parameter int       H_SYNC = 96,
  parameter int       H_BP   = 48,
  parameter int       V_ACT  = 480,
  parameter int       V_FP   = 10,
  parameter int       V_SYNC = 2,
  parameter int       V_BP   = 33,
  parameter logic     HS_POL = 1'b0,
  parameter logic     VS_POL = 1'b0,
  parameter int       XW     = 12,
  parameter int       YW     = 12,
  parameter int       DW     = 4
) (
  input  logic          CLK_VIDEO,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic [DW-1:0] CE_DIV,
  output logic          CE_PIXEL,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic          HBLANK,
  output logic          VBLANK,
  output logic [XW-1:0] PIX_X,
  output logic [YW-1:0] PIX_Y,
  output logic          LINE_START,
  output logic          FRAME_START
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOT - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOT - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_lat;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  logic [31:0] x32;
  logic [31:0] y32;
  logic        div_hit;
  logic        step;
  logic        x_wrap;
  logic        last_pix;
  logic        hb_n;
  logic        vb_n;
  logic        hs_act;
  logic        vs_act;

  // Decode of the position about to be presented; compared in 32 bits so a sync
  // window ending exactly at 2^XW cannot wrap to zero.
  always_comb begin
    x32      = 32'(nx);
    y32      = 32'(ny);
    div_hit  = (div_cnt == div_lat);
    step     = ENABLE && div_hit;
    x_wrap   = (nx == H_LAST);
    last_pix = x_wrap && (ny == V_LAST);
    hb_n     = (x32 >= H_ACT);
    vb_n     = (y32 >= V_ACT);
    hs_act   = (x32 >= H_ACT + H_FP) && (x32 < H_ACT + H_FP + H_SYNC);
    vs_act   = (y32 >= V_ACT + V_FP) && (y32 < V_ACT + V_FP + V_SYNC);
  end

  // Pixel clock divider; the ratio only changes at the frame boundary so a frame
  // never mixes pixel rates.
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      div_cnt  <= '0;
      div_lat  <= CE_DIV;
      CE_PIXEL <= 1'b0;
    end else if (step) begin
      div_cnt  <= '0;
      CE_PIXEL <= 1'b1;
      if (last_pix) begin
        div_lat <= CE_DIV;
      end
    end else begin
      CE_PIXEL <= 1'b0;
      if (ENABLE) begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Next-position counters, advanced once per pixel enable.
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      nx <= '0;
      ny <= '0;
    end else if (step) begin
      if (x_wrap) begin
        nx <= '0;
        ny <= (ny == V_LAST) ? '0 : ny + YW'(1);
      end else begin
        nx <= nx + XW'(1);
      end
    end
  end

  // Registered outputs take the decode on the same edge that raises CE_PIXEL,
  // and hold between pulses; strobes live for that one cycle only.
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_DE      <= 1'b0;
      HBLANK      <= 1'b1;
      VBLANK      <= 1'b1;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (step) begin
      VGA_HS      <= hs_act ? HS_POL : ~HS_POL;
      VGA_VS      <= vs_act ? VS_POL : ~VS_POL;
      VGA_DE      <= !hb_n && !vb_n;
      HBLANK      <= hb_n;
      VBLANK      <= vb_n;
      PIX_X       <= nx;
      PIX_Y       <= ny;
      LINE_START  <= (nx == '0);
      FRAME_START <= (nx == '0) && (ny == '0);
    end else begin
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator. Replaces the fixed 640x480 counter and hard-wired CE_PIXEL=1 in the core top level.
- Produces sync, blanking, data-enable, pixel coordinates and frame/line strobes for any progressive mode set by parameters.
- Generates its own pixel clock enable from a runtime divider, so one video clock can serve cores with different pixel rates.
- Sits between the core's pixel source and the VGA_* / CE_PIXEL outputs of emu.

Parameters:
- H_ACT, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACT, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: HS active level (0 = active low).
- VS_POL, 0: VS active level (0 = active low).
- XW, 12: PIX_X width. Requires H_ACT+H_FP+H_SYNC+H_BP <= 2^XW.
- YW, 12: PIX_Y width. Same rule applies to the vertical total.
- DW, 4: CE_DIV width.

Ports:
- CLK_VIDEO  in  1  video clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  run enable; low freezes all timing.
- CE_DIV  in  DW  pixel clock divide ratio minus 1.
- CE_PIXEL  out  1  pixel clock enable, one CLK_VIDEO cycle wide.
- VGA_HS  out  1  horizontal sync, polarity per HS_POL.
- VGA_VS  out  1  vertical sync, polarity per VS_POL.
- VGA_DE  out  1  active video.
- HBLANK  out  1  horizontal blanking.
- VBLANK  out  1  vertical blanking.
- PIX_X  out  XW  current horizontal position.
- PIX_Y  out  YW  current vertical position.
- LINE_START  out  1  strobe on the first pixel of each line.
- FRAME_START  out  1  strobe on pixel (0,0).

Behaviour:
- Derived totals: H_TOT = H_ACT+H_FP+H_SYNC+H_BP; V_TOT likewise.
- Line order is active, front porch, sync, back porch. Vertical order is the same.
- Reset values (same cycle RESET is sampled high):
  - CE_PIXEL=0, VGA_DE=0, LINE_START=0, FRAME_START=0.
  - HBLANK=1, VBLANK=1, PIX_X=0, PIX_Y=0.
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - Divider counter=0; next position=(0,0); CE_DIV latched into div_lat.
- Divider: counts 0..div_lat. When count==div_lat and ENABLE=1, the count wraps to 0 and CE_PIXEL is registered high for one cycle.
  - First CE_PIXEL is on rising edge div_lat+1 after RESET deasserts.
  - div_lat=0 gives CE_PIXEL high on every cycle.
- Position update: on the edge that asserts CE_PIXEL, all other outputs take the decode of the next position. Then next position advances:
  - x+1, wrapping to 0 at H_TOT-1.
  - y+1 on x wrap, with y wrapping to 0 at V_TOT-1.
  - Outputs hold between CE pulses; zero extra latency relative to CE_PIXEL.
- Decode of (x,y):
  - HBLANK = x>=H_ACT; VBLANK = y>=V_ACT; VGA_DE = !HBLANK & !VBLANK.
  - HS active for H_ACT+H_FP <= x < H_ACT+H_FP+H_SYNC.
  - VS active for V_ACT+V_FP <= y < V_ACT+V_FP+V_SYNC, asserted on whole lines starting at x=0.
  - PIX_X=x, PIX_Y=y across the full total range, not only the active area.
- Strobes: LINE_START = (x==0) & CE_PIXEL edge; FRAME_START = (x==0 & y==0) & CE_PIXEL edge. Both fall on the next cycle.
- CE_DIV is sampled only:
  - on the cycle the last pixel (H_TOT-1, V_TOT-1) is issued, and
  - during RESET.
  - Mid-frame CE_DIV changes have no effect until the next frame.
- ENABLE=0:
  - Divider and position counters hold; CE_PIXEL=0; other outputs hold their values.
  - On re-enable, the divider continues from its held count. No pixel is skipped or repeated.
- RESET mid-frame takes priority over ENABLE and CE. It aborts immediately to reset values; the next frame starts at (0,0) with FRAME_START.
- div_lat is unsigned DW bits; the maximum ratio is 2^DW.

Test Plan:
- Defaults, CE_DIV=0, ENABLE=1:
  - CE_PIXEL high every cycle; FRAME_START every 420000 cycles; LINE_START every 800 cycles.
  - VGA_HS low for x=656..751; VGA_VS low for y=490..491; VGA_DE high for exactly 307200 CE pulses per frame.
- Small mode (H 4/1/2/1, V 3/1/1/1, CE_DIV=0): exhaustively compare all 48 positions of 2 frames against a reference model.
  - H_TOT=8, V_TOT=6.
  - HS active at x=5,6; VS active on y=4; DE for x<4, y<3.
- Divider change: CE_DIV=0 initially; write CE_DIV=2 mid-frame.
  - Current frame keeps 1-cycle pixels.
  - After FRAME_START, CE_PIXEL appears every 3rd cycle; frame period becomes 1260000 cycles (defaults).
- Freeze: with CE_DIV=1, drop ENABLE at x=100,y=20 for 37 cycles.
  - CE_PIXEL=0 and outputs frozen throughout.
  - After resume, the next CE presents x=101 with spacing restored to 2 cycles.
- Reset mid-frame at y=300: next cycle all outputs match reset values.
  - First CE after release carries FRAME_START=1, PIX_X=0, PIX_Y=0, VGA_DE=1.
- Polarity: HS_POL=1, VS_POL=1 gives sync high only in the sync windows, and low during reset.
